// File: rtl/pkt_h.sv
`default_nettype none
// ============================================================================
// Package  : pkt_h
// Purpose  : Shared packet-header type, scheduler mode enum, class helper.
// Revision : 0.2
// ============================================================================
package pkt_h;

  typedef logic [31:0] pkHeadInfo;

  typedef enum logic {
    SCHED_STRICT = 1'b0,
    SCHED_RR     = 1'b1
  } sched_mode_e;

  // Class index lives in the low header bits; at most 8 classes are supported.
  function automatic logic [2:0] pkt_class(input pkHeadInfo info, input int cls_bits);
    logic [2:0] mask;
    mask = 3'((32'd1 << cls_bits) - 32'd1);
    return info[2:0] & mask;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pkt_sche_v0_2_if.sv
`default_nettype none
// ============================================================================
// Interface : pkt_sche_v0_2_if
// Purpose   : Enqueue/dequeue handshake bundle of the packet scheduler.
// Revision  : 0.2
// ============================================================================
interface pkt_sche_v0_2_if #(
  parameter int DWIDTH = 32
);
  import pkt_h::*;

  logic              ready;
  logic              in_valid;
  logic              in_enque_en;
  logic              in_ugr_en;
  pkHeadInfo         in_pkt_info;
  logic [DWIDTH-1:0] in_data;
  logic              out_valid;
  logic              out_deque_en;
  logic [DWIDTH-1:0] out_data;
  pkHeadInfo         out_pkt_info;
  logic              out_ugr;
  logic [15:0]       drop_cnt;

  modport master (
    output in_enque_en, in_ugr_en, in_pkt_info, in_data, out_deque_en,
    input  ready, in_valid, out_valid, out_data, out_pkt_info, out_ugr, drop_cnt
  );

  modport slave (
    input  in_enque_en, in_ugr_en, in_pkt_info, in_data, out_deque_en,
    output ready, in_valid, out_valid, out_data, out_pkt_info, out_ugr, drop_cnt
  );

endinterface

`default_nettype wire

// File: rtl/pkt_fifo.sv
`default_nettype none
// ============================================================================
// Module   : pkt_fifo
// Purpose  : Show-ahead register-array FIFO with occupancy count.
// Revision : 0.2
// ============================================================================
module pkt_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 16
) (
  input  wire                     clk,
  input  wire                     rst,
  input  wire                     wr_en,
  input  wire  [WIDTH-1:0]        wr_data,
  input  wire                     rd_en,
  output logic [WIDTH-1:0]        rd_data,
  output logic                    empty,
  output logic                    full,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int          c_aw   = $clog2(DEPTH);
  localparam logic [c_aw:0] c_full = (c_aw+1)'(DEPTH);
  localparam logic [c_aw:0] c_one  = (c_aw+1)'(1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_aw-1:0]  r_wr_ptr;
  logic [c_aw-1:0]  r_rd_ptr;
  logic [c_aw:0]    r_count;
  logic             w_push;
  logic             w_pop;

  assign empty   = (r_count == '0);
  assign full    = (r_count == c_full);
  assign w_push  = wr_en && !full;
  assign w_pop   = rd_en && !empty;
  assign rd_data = r_mem[r_rd_ptr];
  assign count   = r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + c_aw'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_aw'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_one;
        2'b01:   r_count <= r_count - c_one;
        default: ;
      endcase
    end
  end

  // Storage is not reset; stale words are unreachable once pointers clear.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= wr_data;
  end

endmodule

`default_nettype wire

// File: rtl/pkt_sche_v0_2.sv
`default_nettype none
// ============================================================================
// Module   : pkt_sche_v0_2
// Purpose  : Per-class + urgent packet queues with strict/RR arbitration.
// Revision : 0.2
// ============================================================================
module pkt_sche_v0_2
  import pkt_h::*;
#(
  parameter int          DWIDTH = 32,
  parameter int          NCLASS = 4,
  parameter int          DEPTH  = 16,
  parameter int          UDEPTH = 4,
  parameter sched_mode_e MODE   = SCHED_RR
) (
  input wire              clk,
  input wire              rst,
  pkt_sche_v0_2_if.slave  bus
);

  localparam int CLS_BITS = $clog2(NCLASS);
  localparam int c_word_w = 32 + DWIDTH;
  localparam int c_cnt_w  = $clog2(DEPTH) + 1;
  localparam int c_ucnt_w = $clog2(UDEPTH) + 1;

  logic [CLS_BITS-1:0]       w_cls;
  logic                      w_accept;
  logic                      w_ready;
  logic [NCLASS-1:0]         w_wr_en;
  logic [NCLASS-1:0]         w_rd_en;
  logic [NCLASS-1:0]         w_empty;
  logic [NCLASS-1:0]         w_full;
  logic [c_word_w-1:0]       w_rd_data [NCLASS];
  logic [NCLASS*c_cnt_w-1:0] w_cnt_flat;
  logic                      w_u_wr;
  logic                      w_u_rd;
  logic                      w_u_empty;
  logic                      w_u_full;
  logic [c_word_w-1:0]       w_u_data;
  logic [c_ucnt_w-1:0]       w_u_count;
  logic                      w_sel_ugr;
  logic [CLS_BITS-1:0]       w_sel_cls;
  logic [CLS_BITS-1:0]       w_idx;
  logic                      w_found;
  logic [c_word_w-1:0]       w_sel_word;
  logic                      w_load;
  logic                      w_unused;

  logic                      r_out_valid;
  logic                      r_out_ugr;
  logic [c_word_w-1:0]       r_out_word;
  logic [CLS_BITS-1:0]       r_rr_ptr;
  logic [15:0]               r_drop_cnt;

  assign w_cls    = CLS_BITS'(pkt_class(bus.in_pkt_info, CLS_BITS));
  assign w_ready  = !w_u_full && !(|w_full);
  assign w_accept = bus.in_enque_en && w_ready;
  assign w_u_wr   = w_accept && bus.in_ugr_en;
  assign w_u_rd   = w_load && w_sel_ugr;
  assign w_unused = ^{w_cnt_flat, w_u_count};

  for (genvar i = 0; i < NCLASS; i++) begin : g_cls
    assign w_wr_en[i] = w_accept && !bus.in_ugr_en && (w_cls == CLS_BITS'(i));
    assign w_rd_en[i] = w_load && !w_sel_ugr && (w_sel_cls == CLS_BITS'(i));

    pkt_fifo #(.WIDTH(c_word_w), .DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (w_wr_en[i]),
      .wr_data ({bus.in_pkt_info, bus.in_data}),
      .rd_en   (w_rd_en[i]),
      .rd_data (w_rd_data[i]),
      .empty   (w_empty[i]),
      .full    (w_full[i]),
      .count   (w_cnt_flat[i*c_cnt_w +: c_cnt_w])
    );
  end

  pkt_fifo #(.WIDTH(c_word_w), .DEPTH(UDEPTH)) u_urgent_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (w_u_wr),
    .wr_data ({bus.in_pkt_info, bus.in_data}),
    .rd_en   (w_u_rd),
    .rd_data (w_u_data),
    .empty   (w_u_empty),
    .full    (w_u_full),
    .count   (w_u_count)
  );

  // Urgent wins outright; normal classes are scanned from 0 or from rr_ptr.
  always_comb begin
    w_sel_ugr = !w_u_empty;
    w_sel_cls = '0;
    w_found   = 1'b0;
    w_idx     = '0;
    for (int k = 0; k < NCLASS; k++) begin
      w_idx = (MODE == SCHED_RR) ? r_rr_ptr + CLS_BITS'(k) : CLS_BITS'(k);
      if (!w_found && !w_empty[w_idx]) begin
        w_found   = 1'b1;
        w_sel_cls = w_idx;
      end
    end
    w_sel_word = w_sel_ugr ? w_u_data : w_rd_data[w_sel_cls];
  end

  assign w_load = (!r_out_valid || bus.out_deque_en) && (w_sel_ugr || w_found);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_ugr   <= 1'b0;
      r_out_word  <= '0;
      r_rr_ptr    <= '0;
      r_drop_cnt  <= '0;
    end else begin
      if (w_load) begin
        r_out_valid <= 1'b1;
        r_out_ugr   <= w_sel_ugr;
        r_out_word  <= w_sel_word;
        if (!w_sel_ugr) r_rr_ptr <= w_sel_cls + CLS_BITS'(1);
      end else if (bus.out_deque_en) begin
        r_out_valid <= 1'b0;
      end
      if (bus.in_enque_en && !w_ready && (r_drop_cnt != 16'hFFFF))
        r_drop_cnt <= r_drop_cnt + 16'd1;
    end
  end

  assign bus.ready        = w_ready;
  assign bus.in_valid     = w_accept;
  assign bus.out_valid    = r_out_valid;
  assign bus.out_ugr      = r_out_ugr;
  assign bus.out_pkt_info = r_out_word[c_word_w-1 -: 32];
  assign bus.out_data     = r_out_word[DWIDTH-1:0];
  assign bus.drop_cnt     = r_drop_cnt;

endmodule

`default_nettype wire

// File: tb/tb_pkt_sche_v0_2.sv
`default_nettype none
// ============================================================================
// Module   : tb_pkt_sche_v0_2
// Purpose  : Self-checking bench; one round-robin and one strict-priority DUT.
// Revision : 0.2
// ============================================================================
module tb_pkt_sche_v0_2;
  import pkt_h::*;

  typedef struct packed {
    logic        ugr;
    logic [31:0] info;
    logic [31:0] data;
  } pkt_t;

  typedef struct {
    logic        ugr;
    logic [31:0] info;
    logic [31:0] data;
    logic        exp_acc;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;
  pkt_t exp_q0[$];
  pkt_t exp_q1[$];
  vec_t tab[$];
  int   ord_rr[$];
  int   ord_sp[$];

  pkt_sche_v0_2_if #(.DWIDTH(32)) b0 ();
  pkt_sche_v0_2_if #(.DWIDTH(32)) b1 ();

  pkt_sche_v0_2 #(.DWIDTH(32), .NCLASS(4), .DEPTH(16), .UDEPTH(4), .MODE(SCHED_RR))
    dut_rr (.clk(clk), .rst(rst), .bus(b0));
  pkt_sche_v0_2 #(.DWIDTH(32), .NCLASS(4), .DEPTH(16), .UDEPTH(4), .MODE(SCHED_STRICT))
    dut_sp (.clk(clk), .rst(rst), .bus(b1));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [64:0] act, input logic [64:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_deq(input logic v);
    b0.out_deque_en = v;
    b1.out_deque_en = v;
  endtask

  task automatic drive_idle();
    b0.in_enque_en = 1'b0; b0.in_ugr_en = 1'b0; b0.in_pkt_info = '0; b0.in_data = '0;
    b1.in_enque_en = 1'b0; b1.in_ugr_en = 1'b0; b1.in_pkt_info = '0; b1.in_data = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive_idle();
    set_deq(1'b0);
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic enq(input logic ugr, input logic [31:0] info, input logic [31:0] data,
                     input logic exp_acc);
    b0.in_enque_en = 1'b1; b0.in_ugr_en = ugr; b0.in_pkt_info = info; b0.in_data = data;
    b1.in_enque_en = 1'b1; b1.in_ugr_en = ugr; b1.in_pkt_info = info; b1.in_data = data;
    #1;
    chk("in_valid_rr", 65'(b0.in_valid), 65'(exp_acc));
    chk("in_valid_sp", 65'(b1.in_valid), 65'(exp_acc));
    step();
    drive_idle();
  endtask

  task automatic chk_out(input int d, input logic v, input logic [31:0] info,
                         input logic [31:0] data, input logic ugr);
    pkt_t act;
    pkt_t e;
    if (!v) return;
    act = '{ugr: ugr, info: info, data: data};
    if ((d == 0 && exp_q0.size() == 0) || (d == 1 && exp_q1.size() == 0)) begin
      n_checks++;
      n_errors++;
      $display("FAIL extra_out_d%0d actual=%0h required=none", d, act);
      return;
    end
    e = (d == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
    chk($sformatf("out_pkt_d%0d", d), 65'(act), 65'(e));
  endtask

  task automatic drain(input string tag, input int bound);
    int cyc = 0;
    set_deq(1'b1);
    while ((exp_q0.size() != 0 || exp_q1.size() != 0) && cyc < bound) begin
      chk_out(0, b0.out_valid, b0.out_pkt_info, b0.out_data, b0.out_ugr);
      chk_out(1, b1.out_valid, b1.out_pkt_info, b1.out_data, b1.out_ugr);
      step();
      cyc++;
    end
    if (exp_q0.size() != 0 || exp_q1.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s_timeout actual=%0d/%0d pending required=0", tag,
               exp_q0.size(), exp_q1.size());
      exp_q0.delete();
      exp_q1.delete();
    end
    chk({tag, "_idle_rr"}, 65'(b0.out_valid), 65'(0));
    chk({tag, "_idle_sp"}, 65'(b1.out_valid), 65'(0));
  endtask

  task automatic add_vec(input logic ugr, input logic [31:0] info, input logic [31:0] data,
                         input logic exp_acc);
    vec_t v;
    v.ugr = ugr; v.info = info; v.data = data; v.exp_acc = exp_acc;
    tab.push_back(v);
  endtask

  task automatic run_table(input string tag);
    for (int i = 0; i < tab.size(); i++)
      enq(tab[i].ugr, tab[i].info, tab[i].data, tab[i].exp_acc);
    for (int k = 0; k < ord_rr.size(); k++)
      exp_q0.push_back('{ugr: tab[ord_rr[k]].ugr, info: tab[ord_rr[k]].info,
                         data: tab[ord_rr[k]].data});
    for (int k = 0; k < ord_sp.size(); k++)
      exp_q1.push_back('{ugr: tab[ord_sp[k]].ugr, info: tab[ord_sp[k]].info,
                         data: tab[ord_sp[k]].data});
    drain(tag, 30);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();

    // Reset state
    chk("rst_ready_rr", 65'(b0.ready), 65'(1));
    chk("rst_ready_sp", 65'(b1.ready), 65'(1));
    chk("rst_out_valid", 65'(b0.out_valid), 65'(0));
    chk("rst_in_valid", 65'(b0.in_valid), 65'(0));
    chk("rst_drop_cnt", 65'(b0.drop_cnt), 65'(0));
    chk("rst_out_data", 65'(b1.out_data), 65'(0));
    chk("rst_out_ugr", 65'(b1.out_ugr), 65'(0));

    // Single packet: two-cycle latency, then idle
    set_deq(1'b1);
    exp_q0.push_back('{ugr: 1'b0, info: 32'h0011_4514, data: 32'h114});
    exp_q1.push_back('{ugr: 1'b0, info: 32'h0011_4514, data: 32'h114});
    enq(1'b0, 32'h0011_4514, 32'h114, 1'b1);
    chk("lat1_valid", 65'(b0.out_valid), 65'(0));
    step();
    chk("lat2_valid_rr", 65'(b0.out_valid), 65'(1));
    chk("lat2_valid_sp", 65'(b1.out_valid), 65'(1));
    chk_out(0, b0.out_valid, b0.out_pkt_info, b0.out_data, b0.out_ugr);
    chk_out(1, b1.out_valid, b1.out_pkt_info, b1.out_data, b1.out_ugr);
    step();
    chk("lat3_clear", 65'(b0.out_valid), 65'(0));
    chk("lat_q_empty", 65'(exp_q0.size() + exp_q1.size()), 65'(0));
    exp_q0.delete();
    exp_q1.delete();

    // Class order: RR expects 0,1,2,3,0; strict expects 0,0,1,2,3
    do_reset();
    tab.delete();
    add_vec(1'b0, 32'hA000_0000, 32'hD000_0001, 1'b1);
    add_vec(1'b0, 32'hA000_0010, 32'hD000_0002, 1'b1);
    add_vec(1'b0, 32'hA000_0021, 32'hD000_0003, 1'b1);
    add_vec(1'b0, 32'hA000_0032, 32'hD000_0004, 1'b1);
    add_vec(1'b0, 32'hA000_0043, 32'hD000_0005, 1'b1);
    ord_rr = '{0, 2, 3, 4, 1};
    ord_sp = '{0, 1, 2, 3, 4};
    run_table("order");

    // Urgent bypass while the output register holds class 0 (rr_ptr=1);
    // pending class 1 must still precede class 2 after the urgent service.
    do_reset();
    tab.delete();
    add_vec(1'b0, 32'hB000_0000, 32'hE000_0001, 1'b1);
    add_vec(1'b0, 32'hB000_0002, 32'hE000_0002, 1'b1);
    add_vec(1'b1, 32'hB000_0001, 32'hE000_0003, 1'b1);
    add_vec(1'b0, 32'hB000_0005, 32'hE000_0004, 1'b1);
    ord_rr = '{0, 2, 3, 1};
    ord_sp = '{0, 2, 3, 1};
    run_table("urgent");

    // Fill class 0: 16 in FIFO + 1 in output register, then 3 drops
    do_reset();
    for (int i = 0; i < 20; i++) begin
      logic acc;
      acc = (i < 17);
      enq(1'b0, 32'hC000_0000 + 32'(i << 4), 32'h5000 + 32'(i), acc);
      if (acc) begin
        exp_q0.push_back('{ugr: 1'b0, info: 32'hC000_0000 + 32'(i << 4), data: 32'h5000 + 32'(i)});
        exp_q1.push_back('{ugr: 1'b0, info: 32'hC000_0000 + 32'(i << 4), data: 32'h5000 + 32'(i)});
      end
      if (i == 15) chk("ready_before_full", 65'(b0.ready), 65'(1));
      if (i == 16) begin
        chk("ready_full_rr", 65'(b0.ready), 65'(0));
        chk("ready_full_sp", 65'(b1.ready), 65'(0));
      end
    end
    chk("drop_cnt_rr", 65'(b0.drop_cnt), 65'(3));
    chk("drop_cnt_sp", 65'(b1.drop_cnt), 65'(3));
    drain("full", 60);

    // Reset mid-stream with 5 packets queued
    set_deq(1'b0);
    enq(1'b0, 32'hF000_0000, 32'h6000_0001, 1'b1);
    enq(1'b0, 32'hF000_0001, 32'h6000_0002, 1'b1);
    enq(1'b1, 32'hF000_0002, 32'h6000_0003, 1'b1);
    enq(1'b0, 32'hF000_0003, 32'h6000_0004, 1'b1);
    enq(1'b0, 32'hF000_0000, 32'h6000_0005, 1'b1);
    rst = 1'b1;
    step();
    chk("mrst_out_valid", 65'(b0.out_valid), 65'(0));
    chk("mrst_out_ugr", 65'(b0.out_ugr), 65'(0));
    chk("mrst_out_data", 65'(b0.out_data), 65'(0));
    chk("mrst_out_info", 65'(b0.out_pkt_info), 65'(0));
    chk("mrst_drop_cnt", 65'(b0.drop_cnt), 65'(0));
    chk("mrst_ready", 65'(b0.ready), 65'(1));
    chk("mrst_in_valid", 65'(b0.in_valid), 65'(0));
    chk("mrst_out_valid_sp", 65'(b1.out_valid), 65'(0));
    rst = 1'b0;
    set_deq(1'b1);
    exp_q0.push_back('{ugr: 1'b0, info: 32'hD000_0002, data: 32'h7777});
    exp_q1.push_back('{ugr: 1'b0, info: 32'hD000_0002, data: 32'h7777});
    enq(1'b0, 32'hD000_0002, 32'h7777, 1'b1);
    chk("post_lat1", 65'(b0.out_valid), 65'(0));
    step();
    chk("post_lat2", 65'(b0.out_valid), 65'(1));
    chk_out(0, b0.out_valid, b0.out_pkt_info, b0.out_data, b0.out_ugr);
    chk_out(1, b1.out_valid, b1.out_pkt_info, b1.out_data, b1.out_ugr);
    for (int c = 0; c < 4; c++) begin
      step();
      chk("post_no_stale_rr", 65'(b0.out_valid), 65'(0));
      chk("post_no_stale_sp", 65'(b1.out_valid), 65'(0));
    end
    chk("post_q_empty", 65'(exp_q0.size() + exp_q1.size()), 65'(0));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
